// File: rtl/fetch_stage_pkg.sv
// rv32i_types: shared RV32I word, fetch FSM state and instruction-buffer types
package rv32i_types;
  typedef logic [31:0] rv32i_word;
  typedef enum logic [1:0] {FS_REQ, FS_HAVE, FS_DRAIN} fetch_state_t;
  typedef struct packed {
    rv32i_word pc;
    rv32i_word instr;
  } instr_buf_t;
  localparam rv32i_word PC_STEP = 32'd4;
  function automatic rv32i_word pc_inc(input rv32i_word pc);
    return pc + PC_STEP;
  endfunction
endpackage

// File: rtl/fetch_stage_pc_register.sv
// pc_register: loadable program-counter register with synchronous reset
module pc_register
  import rv32i_types::*;
#(
  parameter rv32i_word RESET_VAL = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] pc_i,
  output logic [31:0] pc_o
);
  rv32i_word pc_q;
  always_ff @(posedge clk)
    if (rst) pc_q <= RESET_VAL;
    else if (load_i) pc_q <= pc_i;
  assign pc_o = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: one-outstanding-read instruction fetch with a single-entry buffer feeding IF/ID
module fetch_stage
  import rv32i_types::*;
#(
  parameter rv32i_word RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic [31:0] instr_out,
  output logic        instr_valid
);
  fetch_state_t state_q, state_d;
  rv32i_word    req_addr_q, req_addr_d, fetch_pc, pc_nx;
  instr_buf_t   buf_q, buf_d;
  logic         pc_ld;
  pc_register #(.RESET_VAL(RESET_PC)) u_pc (
    .clk    (clk),
    .rst    (rst),
    .load_i (pc_ld),
    .pc_i   (pc_nx),
    .pc_o   (fetch_pc)
  );
  // req_addr only moves once the outstanding read has completed, so the bus address stays stable
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    buf_d      = buf_q;
    pc_ld      = 1'b0;
    pc_nx      = redirect_pc;
    case (state_q)
      FS_REQ:
        if (redirect) begin
          pc_ld      = 1'b1;
          state_d    = imem_resp ? FS_REQ : FS_DRAIN;
          req_addr_d = imem_resp ? redirect_pc : req_addr_q;
        end else if (imem_resp) begin
          state_d = FS_HAVE;
          buf_d   = '{pc: req_addr_q, instr: imem_rdata};
        end
      FS_HAVE:
        if (redirect || !stall) begin
          pc_ld      = 1'b1;
          pc_nx      = redirect ? redirect_pc : pc_inc(buf_q.pc);
          req_addr_d = pc_nx;
          state_d    = FS_REQ;
        end
      default: begin
        pc_ld      = redirect;
        req_addr_d = imem_resp ? (redirect ? redirect_pc : fetch_pc) : req_addr_q;
        state_d    = imem_resp ? FS_REQ : FS_DRAIN;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q    <= FS_REQ;
      req_addr_q <= RESET_PC;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      buf_q      <= buf_d;
    end
  assign imem_read    = !rst && state_q != FS_HAVE;
  assign imem_address = req_addr_q;
  assign instr_valid  = state_q == FS_HAVE;
  assign pc_out       = buf_q.pc;
  assign instr_out    = buf_q.instr;
  assign pc_plus4_out = pc_inc(buf_q.pc);
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch traffic against a next-PC reference model with a response scoreboard
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  logic        clk = 1'b0;
  logic        rst, stall, redirect, imem_resp;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_read, instr_valid;
  logic [31:0] imem_address, pc_out, pc_plus4_out, instr_out;
  typedef struct {
    logic        acc;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;
  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .pc_out       (pc_out),
    .pc_plus4_out (pc_plus4_out),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F13;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Stimulus, memory responder and next-PC model; the model only knows "next PC to deliver"
  initial begin
    logic [31:0] targets [5];
    logic [31:0] mpc, hold;
    bit          out, stale, held;
    int          wait_n;
    targets = '{32'h8000_0100, 32'h8000_0200, 32'hFFFF_FFFC, 32'h0000_0010, 32'hFFFF_FFF8};
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_resp = 1'b0; imem_rdata = '0;
    mpc = RST_PC; hold = '0; out = 0; stale = 0; held = 0; wait_n = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (cyc < 2 || cyc == 1500 || cyc == 1501) begin
        rst = 1'b1; out = 0; stale = 0; held = 0; mpc = RST_PC;
        imem_resp = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        redirect = 1'($urandom_range(0, 1));
        redirect_pc = targets[$urandom_range(0, 4)];
        stall = 1'($urandom_range(0, 1));
        continue;
      end
      rst = 1'b0;
      imem_resp = 1'b0;
      if (out) begin
        chk("addr_hold", imem_address, hold);
        chk("read_held", 32'(imem_read), 32'd1);
        if (wait_n == 0) imem_resp = 1'b1;
        else wait_n--;
      end else if (imem_read) begin
        out = 1; hold = imem_address; wait_n = int'($urandom_range(0, 2));
        chk("req_addr", imem_address, mpc);
      end
      imem_rdata  = imem_resp ? word_at(hold) : $urandom;
      stall       = $urandom_range(0, 9) < 4;
      redirect    = $urandom_range(0, 9) == 0;
      redirect_pc = redirect ? targets[$urandom_range(0, 4)] : $urandom;
      if (imem_resp) begin
        sb.push_back('{acc: !stale && !redirect, pc: mpc});
        held  = !stale && !redirect;
        out   = 0;
        stale = 0;
      end else if (redirect && out) stale = 1;
      if (redirect) begin
        mpc  = redirect_pc;
        held = 0;
      end else if (held && !stall) begin
        mpc  = mpc + 32'd4;
        held = 0;
      end
    end
    @(posedge clk);
    #2;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  // Monitor: pops one expectation per completed read and checks hold/drop behaviour in between
  initial begin
    exp_t        e;
    logic [31:0] lpc, linstr;
    bit          lv;
    int          idle;
    lv = 0; lpc = '0; linstr = '0; idle = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk("rst_read", 32'(imem_read), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        lv = 0;
        idle = 0;
      end else begin
        if (imem_resp) begin
          if (sb.size() == 0) begin
            checks++; fails++;
            $display("FAIL sb_underflow: got response with no expectation, required one queued");
          end else begin
            e = sb.pop_front();
            chk("valid_after_resp", 32'(instr_valid), 32'(e.acc));
            if (e.acc) begin
              chk("pc_out", pc_out, e.pc);
              chk("instr_out", instr_out, word_at(e.pc));
              chk("pc_plus4_out", pc_plus4_out, e.pc + 32'd4);
            end
          end
        end else begin
          chk("valid_hold", 32'(instr_valid), 32'(lv && stall && !redirect));
          if (instr_valid && lv) begin
            chk("stall_pc", pc_out, lpc);
            chk("stall_instr", instr_out, linstr);
          end
        end
        chk(instr_valid ? "read_in_have" : "read_in_req", 32'(imem_read), 32'(!instr_valid));
        lv = instr_valid; lpc = pc_out; linstr = instr_out;
        idle = instr_valid ? 0 : idle + 1;
        if (idle >= 200) begin
          checks++; fails++;
          $display("FAIL progress: got %0d cycles without instr_valid, required fewer than 200", idle);
          idle = 0;
        end
      end
    end
  end
endmodule
